program_memory_loader: RTL
==========================

PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 14, instruction word width.
- ADDR_W, 11, address width.
- DEPTH, 2**ADDR_W, number of words, with DEPTH <= 2**ADDR_W.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_data  out  DATA_W  registered fetch result.
- fetch_valid  out  1  fetch_data holds a result for the previous cycle's request.
- ld_start  in  1  load request pulse.
- ld_base  in  ADDR_W  first load address.
- ld_len  in  ADDR_W+1  number of words to load.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  load word.
- ld_ready  out  1  block accepts a load word this cycle.
- ld_busy  out  1  load in progress.
- ld_done  out  1  one-cycle load-complete pulse.
- ld_err  out  1  sticky error flag.
- ld_checksum  out  DATA_W  running sum of accepted words.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-005 Storage SHALL be a DEPTH x DATA_W array; reset SHALL NOT clear it.
REQ-006 Fetch in IDLE SHALL behave as follows:
- fetch_en=1 at an edge: fetch_data <= mem[fetch_addr] and fetch_valid <= 1 (1-cycle latency).
- fetch_en=0: fetch_valid <= 0 and fetch_data holds its value.
REQ-007 A fetch with fetch_addr >= DEPTH SHALL return 0 (NOP) with fetch_valid=1.
REQ-008 In LOAD and DONE, fetch_valid SHALL be 0 and fetch_data SHALL be 0, regardless of fetch_en.
REQ-009 An ld_start in IDLE SHALL do the following:
- Latch ld_base into the write pointer and ld_len into the remaining count.
- Clear ld_err and ld_checksum.
- Evaluate legality.
REQ-010 A load SHALL be illegal when ld_len==0 or ld_base+ld_len > DEPTH (computed without overflow).
- Illegal load: set ld_err=1 and go to DONE; no words written.
- Legal load: go to LOAD.
REQ-011 In LOAD, ld_ready=1 and ld_busy=1.
REQ-012 Each cycle with ld_valid&&ld_ready SHALL do the following:
- Write mem[ptr] <= ld_data.
- Increment ptr and decrement remaining.
- Update ld_checksum <= (ld_checksum + ld_data) mod 2**DATA_W.
REQ-013 A cycle in LOAD with ld_valid=0 SHALL change nothing.
REQ-014 Acceptance of the last word SHALL move the FSM to DONE on that same edge, and ld_ready SHALL be 0 in DONE.
REQ-015 DONE SHALL last exactly one cycle.
- ld_done=1, ld_busy=1, ld_ready=0.
- Then return to IDLE.
REQ-016 ld_start SHALL be ignored in LOAD and DONE.
REQ-017 When fetch_en and ld_start are both high in IDLE, both SHALL be serviced.
- The fetch returns pre-load contents with fetch_valid=1.
- The FSM enters LOAD (or DONE if the load is illegal).
REQ-018 A fetch issued in IDLE after ld_done SHALL return the newly loaded data.
REQ-019 ld_checksum and ld_err SHALL hold their values in IDLE until the next ld_start.
REQ-020 The write pointer SHALL never wrap; the REQ-010 legality check guarantees ptr stays <= DEPTH-1.

Reset
REQ-021 On rst_n=0, the block SHALL immediately force:
- state=IDLE.
- fetch_data=0, fetch_valid=0.
- ld_ready=0, ld_busy=0, ld_done=0, ld_err=0, ld_checksum=0.
- ptr=0, remaining=0.
REQ-022 A reset mid-LOAD SHALL abort the load.
- Words already written remain in memory.
- Unwritten words keep their prior contents.
- No ld_done pulse is produced.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Legal load: ld_base=0, ld_len=3, words 0x3004, 0x00A5, 0x300A back-to-back.
  - Required: ld_ready high for 3 cycles; ld_done pulses on the cycle after the 3rd acceptance; ld_checksum=0x20B3.
  - Then fetch_en with fetch_addr=1: fetch_data=0x00A5 and fetch_valid=1 one cycle later.
- Gapped handshake: ld_len=4 with ld_valid alternating 1/0.
  - Required: exactly 4 writes; ld_done only after the 4th acceptance; no write on ld_valid=0 cycles.
- Illegal loads: DEPTH=2048 with (ld_base=0x7FE, ld_len=3), then ld_len=0.
  - Required for each: ld_err=1, ld_done pulse, ld_ready never high, mem[0x7FE] unchanged.
- Fetch during load: fetch_en=1 throughout LOAD.
  - Required: fetch_valid=0 and fetch_data=0 in LOAD/DONE.
  - A second ld_start mid-LOAD is ignored (remaining count and ptr unchanged).
- Reset mid-load: rst_n low after 2 of 4 words (base 0x10, old contents 0x0000).
  - Required: all outputs at reset values immediately; mem[0x10..0x11] hold new words; mem[0x12..0x13] = 0x0000.
- Simultaneous fetch and load start: fetch_en and ld_start together, fetch_addr=ld_base=5, mem[5]=0x3001, first load word 0x2810.
  - Required: fetch_data=0x3001 with fetch_valid=1.
  - After ld_done, a fetch of address 5 returns 0x2810.

Source files
------------

// File: rtl/program_memory_loader.sv
// Program memory with a registered fetch port and a streaming loader.
// Loads are bounds-checked up front so the write pointer never leaves the array.
module program_memory_loader #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [DATA_W-1:0] ld_checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;

    logic [ADDR_W+1:0] ld_end;
    logic              ld_illegal;
    logic              fetch_oob;
    logic              accept;
    logic              last_word;
    logic [DATA_W-1:0] rd_word;

    // One extra bit of headroom keeps base+len from wrapping in the bounds check.
    assign ld_end     = {2'b00, ld_base} + {1'b0, ld_len};
    assign ld_illegal = (ld_len == '0) || (ld_end > DEPTH_X);
    assign fetch_oob  = ({2'b00, fetch_addr} >= DEPTH_X);
    assign accept     = ld_valid && ld_ready;
    assign last_word  = (remaining == (ADDR_W+1)'(1));

    always_comb begin
        rd_word = '0;
        if (!fetch_oob)
            rd_word = mem[fetch_addr];
    end

    // No reset on the array: contents survive reset, including a partial load.
    always_ff @(posedge clk) begin
        if (accept)
            mem[ptr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            ld_ready    <= 1'b0;
            ld_busy     <= 1'b0;
            ld_done     <= 1'b0;
            ld_err      <= 1'b0;
            ld_checksum <= '0;
            ptr         <= '0;
            remaining   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ld_ready    <= 1'b0;
                    ld_busy     <= 1'b0;
                    ld_done     <= 1'b0;
                    fetch_valid <= fetch_en;
                    if (fetch_en)
                        fetch_data <= rd_word;
                    if (ld_start) begin
                        ptr         <= ld_base;
                        remaining   <= ld_len;
                        ld_checksum <= '0;
                        ld_err      <= ld_illegal;
                        ld_busy     <= 1'b1;
                        if (ld_illegal) begin
                            state   <= DONE;
                            ld_done <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            ld_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    fetch_valid <= 1'b0;
                    fetch_data  <= '0;
                    if (accept) begin
                        remaining   <= remaining - 1'b1;
                        ld_checksum <= ld_checksum + ld_data;
                        // Pointer stays on the last written word so it never wraps.
                        if (last_word) begin
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    fetch_valid <= 1'b0;
                    fetch_data  <= '0;
                    ld_ready    <= 1'b0;
                    ld_done     <= 1'b0;
                    ld_busy     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
